// File: rtl/mdu_unit.sv
// mdu_unit: multi-cycle multiply/divide unit holding the architectural HI/LO registers.
// Results are computed at start into shadow registers and committed when the busy countdown expires.
module mdu_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  mdu_op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        start,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] mdu_out
);
    localparam int CW = $clog2(DIV_CYCLES) + 1;

    typedef enum logic {IDLE, RUN} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   hi_q, hi_d, lo_q, lo_d;
    logic [31:0]   hi_r_q, hi_r_d, lo_r_q, lo_r_d;
    logic          dz_q, dz_d;
    logic          is_mul, is_div, sdiv;
    logic [63:0]   prod;
    logic [31:0]   a_abs, b_abs, b_div, quo, rem, q_res, r_res;

    assign is_mul  = (mdu_op == 4'd1) || (mdu_op == 4'd2);
    assign is_div  = (mdu_op == 4'd3) || (mdu_op == 4'd4);
    assign sdiv    = (mdu_op == 4'd3);
    assign busy    = (state_q == RUN);
    assign start   = (is_mul || is_div) && !busy;
    assign HI      = hi_q;
    assign LO      = lo_q;
    assign mdu_out = (mdu_op == 4'd7) ? hi_q : (mdu_op == 4'd8) ? lo_q : 32'd0;

    assign prod = (mdu_op == 4'd1) ? {{32{A[31]}}, A} * {{32{B[31]}}, B} : {32'd0, A} * {32'd0, B};

    // Signed divide on magnitudes: avoids the 0x80000000 / -1 overflow case and gives
    // truncation toward zero with the remainder taking the dividend's sign.
    assign a_abs = (sdiv && A[31]) ? -A : A;
    assign b_abs = (sdiv && B[31]) ? -B : B;
    assign b_div = (B == 32'd0) ? 32'd1 : b_abs;
    assign quo   = a_abs / b_div;
    assign rem   = a_abs % b_div;
    assign q_res = (sdiv && (A[31] ^ B[31])) ? -quo : quo;
    assign r_res = (sdiv && A[31]) ? -rem : rem;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        hi_r_d  = hi_r_q;
        lo_r_d  = lo_r_q;
        dz_d    = dz_q;
        if (state_q == IDLE) begin
            if (start) begin
                state_d = RUN;
                cnt_d   = is_mul ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
                hi_r_d  = is_mul ? prod[63:32] : r_res;
                lo_r_d  = is_mul ? prod[31:0] : q_res;
                dz_d    = is_div && (B == 32'd0);
            end else begin
                hi_d = (mdu_op == 4'd5) ? A : hi_q;
                lo_d = (mdu_op == 4'd6) ? A : lo_q;
            end
        end else begin
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
                state_d = IDLE;
                hi_d    = dz_q ? hi_q : hi_r_q;
                lo_d    = dz_q ? lo_q : lo_r_q;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            hi_r_q  <= '0;
            lo_r_q  <= '0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            hi_r_q  <= hi_r_d;
            lo_r_q  <= lo_r_d;
            dz_q    <= dz_d;
        end
    end
endmodule

// File: tb/tb_mdu_unit.sv
// tb_mdu_unit: directed-vector bench for mdu_unit with hand-computed HI/LO results and busy lengths.
module tb_mdu_unit;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  mdu_op = 4'd0;
    logic [31:0] A = 32'd0;
    logic [31:0] B = 32'd0;
    logic        start, busy;
    logic [31:0] HI, LO, mdu_out;
    int          errors = 0;
    int          checks = 0;

    mdu_unit dut (
        .clk(clk), .reset(reset), .mdu_op(mdu_op), .A(A), .B(B),
        .start(start), .busy(busy), .HI(HI), .LO(LO), .mdu_out(mdu_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one mult/div op, then count busy cycles and compare final HI/LO.
    task automatic mdu_run(input string tag, input logic [3:0] op, input logic [31:0] a,
                           input logic [31:0] b, input int cyc,
                           input logic [31:0] ehi, input logic [31:0] elo);
        int n;
        mdu_op = op; A = a; B = b;
        #1;
        check({tag, "_start"}, 32'(start), 32'd1);
        tick();
        mdu_op = 4'd0;
        n = 0;
        while (busy && n < 40) begin
            n++;
            tick();
        end
        check({tag, "_busy_cycles"}, n, cyc);
        check({tag, "_hi"}, HI, ehi);
        check({tag, "_lo"}, LO, elo);
    endtask

    initial begin
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_hi", HI, 32'd0);
        check("rst_lo", LO, 32'd0);
        tick();
        reset = 1'b1;
        tick();

        mdu_run("mult", 4'd1, 32'hFFFFFFFE, 32'd3, 5, 32'hFFFFFFFF, 32'hFFFFFFFA);
        mdu_run("multu", 4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 5, 32'hFFFFFFFE, 32'h00000001);
        mdu_run("div", 4'd3, 32'hFFFFFFF9, 32'd2, 10, 32'hFFFFFFFF, 32'hFFFFFFFD);
        mdu_run("divu", 4'd4, 32'hFFFFFFF9, 32'd2, 10, 32'h00000001, 32'h7FFFFFFC);

        mdu_op = 4'd5; A = 32'h12345678;
        #1;
        check("mthi_start", 32'(start), 32'd0);
        tick();
        mdu_op = 4'd7;
        #1;
        check("mthi_hi", HI, 32'h12345678);
        check("mfhi_out", mdu_out, 32'h12345678);
        check("mthi_busy", 32'(busy), 32'd0);
        mdu_op = 4'd8;
        #1;
        check("mflo_out", mdu_out, 32'h7FFFFFFC);
        mdu_op = 4'd0;
        #1;
        check("none_out", mdu_out, 32'd0);

        mdu_run("div0", 4'd3, 32'd55, 32'd0, 10, 32'h12345678, 32'h7FFFFFFC);
        mdu_run("divu0", 4'd4, 32'd55, 32'd0, 10, 32'h12345678, 32'h7FFFFFFC);
        mdu_run("divovf", 4'd3, 32'h80000000, 32'hFFFFFFFF, 10, 32'd0, 32'h80000000);

        // Ops presented while busy must be ignored, then reset mid-operation.
        mdu_op = 4'd3; A = 32'd100; B = 32'd7;
        tick();
        mdu_op = 4'd1; A = 32'd5; B = 32'd5;
        #1;
        check("busy_start_blocked", 32'(start), 32'd0);
        tick();
        mdu_op = 4'd6; A = 32'hDEADBEEF;
        tick();
        mdu_op = 4'd0;
        check("busy_mtlo_ignored", LO, 32'h80000000);
        check("busy_still", 32'(busy), 32'd1);
        tick();
        reset = 1'b0;
        #1;
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_hi", HI, 32'd0);
        check("arst_lo", LO, 32'd0);
        tick();
        reset = 1'b1;
        for (int i = 0; i < 15; i++) tick();
        check("post_rst_busy", 32'(busy), 32'd0);
        check("post_rst_hi", HI, 32'd0);
        check("post_rst_lo", LO, 32'd0);

        mdu_run("b2b_mult", 4'd1, 32'd6, 32'd7, 5, 32'd0, 32'd42);
        mdu_run("b2b_div", 4'd3, 32'hFFFFFF9C, 32'd7, 10, 32'hFFFFFFFE, 32'hFFFFFFF2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
